// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch initiator for a synchronous-read instruction
// memory. Issues one word address per cycle while credit allows, tracks the
// single-cycle read latency and keeps returned words in a two-entry FIFO so a
// stalled decode stage never loses an instruction. Redirects flush all work in
// flight and restart fetching from the new target.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  // Outstanding-work limit: buffered words plus the word in flight.
  localparam logic [1:0]  CREDITS  = BUF_DEPTH[1:0];
  localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;
  localparam logic [31:0] BOOT_PC  = RESET_PC & PC_ALIGN;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        infl_r;
  logic [31:0] infl_pc_r;
  logic [1:0]  cnt_r;
  logic [31:0] b0_pc_r;
  logic [31:0] b0_instr_r;
  logic [31:0] b1_pc_r;
  logic [31:0] b1_instr_r;

  logic        bypass_s;
  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [1:0]  occ_s;
  logic [1:0]  cnt_nxt_s;
  logic [31:0] b0_pc_nxt_s;
  logic [31:0] b0_instr_nxt_s;
  logic [31:0] b1_pc_nxt_s;
  logic [31:0] b1_instr_nxt_s;

  // The memory is read every cycle at the current word address.
  assign imem_addr = {2'b00, pc_r[31:2]};

  assign pop_s  = out_valid & out_ready;
  // A live response is kept unless it went straight out and was consumed.
  assign push_s = infl_r & ~(bypass_s & pop_s);

  // Output select: buffer head first, else bypass the live response.
  always_comb begin
    bypass_s  = 1'b0;
    out_valid = 1'b0;
    out_pc    = 32'h0000_0000;
    out_instr = 32'h0000_0000;
    if (redirect_valid) begin
      out_valid = 1'b0;
    end else if (cnt_r != 2'd0) begin
      out_valid = 1'b1;
      out_pc    = b0_pc_r;
      out_instr = b0_instr_r;
    end else if (infl_r) begin
      out_valid = 1'b1;
      out_pc    = infl_pc_r;
      out_instr = imem_rdata;
      bypass_s  = 1'b1;
    end else begin
      out_valid = 1'b0;
    end
  end

  // Issue decision: only fetch when the result is guaranteed a buffer slot.
  always_comb begin
    occ_s   = cnt_r + {1'b0, infl_r} - {1'b0, pop_s};
    issue_s = 1'b0;
    case (state_r)
      ST_BOOT: issue_s = ~redirect_valid;
      ST_RUN:  issue_s = ~redirect_valid & (occ_s < CREDITS);
      default: issue_s = 1'b0;
    endcase
  end

  // FIFO next state: remove head on pop, then append the live response.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    b0_pc_nxt_s    = b0_pc_r;
    b0_instr_nxt_s = b0_instr_r;
    b1_pc_nxt_s    = b1_pc_r;
    b1_instr_nxt_s = b1_instr_r;
    if (pop_s && (cnt_r != 2'd0)) begin
      b0_pc_nxt_s    = b1_pc_r;
      b0_instr_nxt_s = b1_instr_r;
      cnt_nxt_s      = cnt_r - 2'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (push_s) begin
      if (cnt_nxt_s == 2'd0) begin
        b0_pc_nxt_s    = infl_pc_r;
        b0_instr_nxt_s = imem_rdata;
      end else begin
        b1_pc_nxt_s    = infl_pc_r;
        b1_instr_nxt_s = imem_rdata;
      end
      cnt_nxt_s = cnt_nxt_s + 2'd1;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Fetch state machine, PC, in-flight tracking and response buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= BOOT_PC;
      infl_r     <= 1'b0;
      infl_pc_r  <= 32'h0000_0000;
      cnt_r      <= 2'd0;
      b0_pc_r    <= 32'h0000_0000;
      b0_instr_r <= 32'h0000_0000;
      b1_pc_r    <= 32'h0000_0000;
      b1_instr_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Drop buffered words and the response arriving next cycle.
      state_r <= ST_RUN;
      pc_r    <= redirect_pc & PC_ALIGN;
      infl_r  <= 1'b0;
      cnt_r   <= 2'd0;
    end else begin
      state_r    <= ST_RUN;
      cnt_r      <= cnt_nxt_s;
      b0_pc_r    <= b0_pc_nxt_s;
      b0_instr_r <= b0_instr_nxt_s;
      b1_pc_r    <= b1_pc_nxt_s;
      b1_instr_r <= b1_instr_nxt_s;
      if (issue_s) begin
        pc_r      <= pc_r + 32'd4;
        infl_r    <= 1'b1;
        infl_pc_r <= pc_r;
      end else begin
        infl_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a 1-cycle synchronous memory model, a
// queue-based reference of issued-but-undelivered fetches, directed scenarios
// and a randomized phase. A second instance checks PC wrap from a high RESET_PC.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;

  logic [31:0] imem_addr2, imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_instr2, out_pc2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        out_ready2 = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: next fetch PC and PCs issued but not yet delivered
  logic [31:0] m_pc;
  logic [31:0] mq[$];

  // last sampled outputs from step()
  logic        s_valid;
  logic [31:0] s_pc, s_instr, s_addr;

  logic [31:0] seq_pc  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] seq_ins [5] = '{32'h10000517, 32'h00050513, 32'h00052583,
                               32'h00C586B3, 32'h00D52423};

  if_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_instr(out_instr2), .out_pc(out_pc2),
    .out_ready(out_ready2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h10000517;
      32'd1:   return 32'h00050513;
      32'd2:   return 32'h00052583;
      32'd3:   return 32'h00C586B3;
      32'd4:   return 32'h00D52423;
      default: return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  // synchronous-read memories, one per instance
  always @(posedge clk) imem_rdata  <= memfn(imem_addr);
  always @(posedge clk) imem_rdata2 <= memfn(imem_addr2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    mq.delete();
    m_pc = rpc & 32'hFFFF_FFFC;
  endtask

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic        exp_valid, pop, iss;
    logic [31:0] exp_pc, exp_instr;
    int          sz;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    sz        = mq.size();
    exp_valid = !redir && (sz > 0);
    exp_pc    = exp_valid ? mq[0] : 32'h0;
    exp_instr = exp_valid ? memfn(mq[0] >> 2) : 32'h0;
    check("imem_addr", imem_addr, m_pc >> 2);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("out_pc", out_pc, exp_pc);
    check("out_instr", out_instr, exp_instr);
    check("no_overflow", {31'd0, (dut.cnt_r <= 2'd2)}, 32'd1);
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_addr  = imem_addr;
    pop = exp_valid && rdy;
    iss = !redir && ((sz - int'(pop)) < 2);
    if (redir) begin
      model_reset(rpc);
    end else begin
      if (pop) void'(mq.pop_front());
      if (iss) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    // reset state
    model_reset(32'h0);
    @(negedge clk); #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // BOOT then streaming with out_ready=1
    step(1'b0, 32'h0, 1'b1);
    check("boot_valid", {31'd0, s_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check("seq_pc", s_pc, seq_pc[i]);
      check("seq_instr", s_instr, seq_ins[i]);
    end

    // restart at 0, then stall for 5 cycles after the first valid
    step(1'b1, 32'h0, 1'b1);
    check("redir_valid0", {31'd0, s_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("stall_pc", s_pc, 32'h0);
      check("stall_instr", s_instr, 32'h10000517);
      if (i > 0) check("stall_addr", s_addr, 32'd2);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check("release_pc", s_pc, seq_pc[i]);
    end

    // stall to fill the buffer, then redirect to an unaligned target
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_000E, 1'b0);
    check("redir_valid", {31'd0, s_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("redir_addr", s_addr, 32'd3);
    check("redir_gap", {31'd0, s_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("redir_tgt_pc", s_pc, 32'hC);
    check("redir_tgt_instr", s_instr, 32'h00C586B3);
    step(1'b0, 32'h0, 1'b1);
    check("redir_next_pc", s_pc, 32'h10);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      logic        rv, rd;
      logic [31:0] rp;
      rv = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 9) < 7);
      rp = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 40));
      step(rv, rp, rd);
    end

    // reach cnt=1 with a word in flight, then assert reset asynchronously
    step(1'b1, 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #3;
    check("pre_rst_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    model_reset(32'h0);
    @(posedge clk); #2 rst = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    check("reboot_valid", {31'd0, s_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("reboot_pc", s_pc, 32'h0);
    check("reboot_instr", s_instr, 32'h10000517);

    // PC wrap on the second instance
    @(posedge clk); #2 rst2 = 1'b0;
    begin
      logic [31:0] w_addr [5];
      logic [31:0] w_pc   [5];
      logic [31:0] w_val  [5];
      w_addr = '{32'h3FFFFFFE, 32'h3FFFFFFF, 32'h0, 32'h1, 32'h2};
      w_pc   = '{32'h0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
      w_val  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); #1;
        check("wrap_addr", imem_addr2, w_addr[i]);
        check("wrap_valid", {31'd0, out_valid2}, w_val[i]);
        check("wrap_pc", out_pc2, w_pc[i]);
        check("wrap_instr", out_instr2, (w_val[i] != 32'd0) ? memfn(w_pc[i] >> 2) : 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
